booth_mult: RTL and testbench
=============================

# booth_mult

Three-channel (R/G/B) sequential radix-2 Booth multiplier for signed Q1.23 fixed-point mantissas. Each channel operand is multiplied by a shared signed coefficient `COEFF`, producing a full-precision signed Q2.46 product per channel. It sits in the colour-processing datapath beneath the floating-point stage, which supplies the 24-bit mantissas and consumes the 48-bit products.

## Interface
- `MANTISSA_WIDTH`, 23: operand width minus one; operands are `MANTISSA_WIDTH+1` bits.
- `COEFF`, 24'h400000: signed Q1.23 multiplicand applied to all three channels (default +0.5).
- `clk_i_fix_multi` in 1: single clock; all logic rising-edge.
- `rst_i_fix_multi` in 1: reset, synchronous, active-high.
- `en_i_fix_multi` in 1: start request, level-sampled in IDLE.
- `data_i_from_upper_Red` in 24: signed Q1.23 multiplier, red.
- `data_i_from_upper_Green` in 24: signed Q1.23 multiplier, green.
- `data_i_from_upper_Blue` in 24: signed Q1.23 multiplier, blue.
- `fixed_multiplication_result_Red_o` out 48: signed Q2.46 product, red.
- `fixed_multiplication_result_Green_o` out 48: signed Q2.46 product, green.
- `fixed_multiplication_result_Blue_o` out 48: signed Q2.46 product, blue.
- `fixed_multiplication_done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `en_i_fix_multi`=1, latch all three data inputs into per-channel Q registers.
  - Clear each channel's A register (25 bits) and Q-1 bit, clear the step counter, then go to RUN.
- RUN, per channel per cycle, inspect {Q0, Q-1}:
  - 01: A ← A + sext25(COEFF).
  - 10: A ← A − sext25(COEFF).
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,Q-1} by one.
  - Counter increments each step. After step 24, go to DONE.
- DONE:
  - Register each product = low 48 bits of {A,Q} into its output.
  - Assert done for this cycle, then return to IDLE.
- A is 25 bits so −1.0 × −1.0 and ±COEFF extremes never overflow. Every product is exact in 48 bits.
- Inputs are sampled only at the IDLE→RUN transition. Input changes during RUN/DONE are ignored.
- `en_i_fix_multi` is ignored in RUN and DONE. If it is still high on return to IDLE, a new operation starts.
- All three channels run in lockstep and share one counter and one FSM.
- Results hold their value until the next DONE.

## Timing
- Reset (synchronous, active-high): state=IDLE, counter=0, A/Q/Q-1=0, all results=0, done=0. Reset takes priority over everything and aborts an in-flight operation with no done pulse.
- Latency: en sampled high in IDLE at edge N; 24 RUN edges N+1..N+24; DONE at N+25, where results update and done=1 for exactly one cycle.
- Throughput: one operation per 26 cycles with en held high (IDLE re-entered for one cycle).
- Done is never asserted for two consecutive cycles.

## Configuration
- `BOOTH_MULT_BUSY_EN` defined:
  - Adds output port `busy_o_fix_multi` (1 bit).
  - High in RUN and DONE, low in IDLE and during/after reset.
- `BOOTH_MULT_BUSY_EN` undefined: the port and its logic do not exist. Behaviour is otherwise identical.

## Test plan
- Reset held, en=1 → all results 0 and done 0 throughout. Release reset → start occurs in the first IDLE cycle.
- COEFF default; R=24'h960000 (−0.828125), G=24'hA00000 (−0.75), B=24'hAA0000 (−0.671875); en pulse → done 25 cycles later with R=48'hE58000000000, G=48'hE80000000000, B=48'hEA8000000000.
- R=G=B=24'h400000 (+0.5) → all results 48'h100000000000 (+0.25).
- R=24'h800000 (−1.0), G=24'h000000, B=24'h7FFFFF → R=48'hE00000000000, G=0, B=48'h1FFFFFC00000.
- With COEFF=24'h800000, R=24'h800000 → R=48'h400000000000 (no overflow). en held high → done pulses every 26 cycles. Inputs changed mid-RUN → no effect on the current result.
- Assert reset at RUN step 10 → no done pulse and outputs 0. Next en → correct products.

Source files
------------

// File: rtl/booth_mult.sv
// Three-channel lockstep radix-2 Booth multiplier: Q1.23 operands times a shared COEFF -> Q2.46.
// Optional busy output enabled by defining BOOTH_MULT_BUSY_EN.
module booth_mult #(
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter logic [MANTISSA_WIDTH:0] COEFF = 24'h400000
) (
  input  logic                        clk_i_fix_multi,
  input  logic                        rst_i_fix_multi,
  input  logic                        en_i_fix_multi,
  input  logic [MANTISSA_WIDTH:0]     data_i_from_upper_Red,
  input  logic [MANTISSA_WIDTH:0]     data_i_from_upper_Green,
  input  logic [MANTISSA_WIDTH:0]     data_i_from_upper_Blue,
  output logic [2*MANTISSA_WIDTH+1:0] fixed_multiplication_result_Red_o,
  output logic [2*MANTISSA_WIDTH+1:0] fixed_multiplication_result_Green_o,
  output logic [2*MANTISSA_WIDTH+1:0] fixed_multiplication_result_Blue_o,
`ifdef BOOTH_MULT_BUSY_EN
  output logic                        busy_o_fix_multi,
`endif
  output logic                        fixed_multiplication_done_o
);

  localparam int unsigned W        = MANTISSA_WIDTH + 1;
  localparam int unsigned AccW     = 2 * W + 2;
  localparam int unsigned CntW     = $clog2(W + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          step_q;
  // Per channel accumulator layout: {A (W+1 bits), Q (W bits), Q-1}
  logic [2:0][AccW-1:0]     acc_q;
  logic [2:0][W-1:0]        din;

  assign din = {data_i_from_upper_Blue, data_i_from_upper_Green, data_i_from_upper_Red};

  function automatic logic [AccW-1:0] booth_step(input logic [AccW-1:0] acc);
    logic [W:0] a;
    logic [W:0] coeff_x;
    a       = acc[AccW-1 -: W+1];
    coeff_x = {COEFF[W-1], COEFF};
    case (acc[1:0])
      2'b01:   a = a + coeff_x;
      2'b10:   a = a - coeff_x;
      default: a = a;
    endcase
    // Arithmetic shift right of {A,Q,Q-1}; old Q0 becomes the new Q-1.
    return {a[W], a, acc[W:1]};
  endfunction

  always_ff @(posedge clk_i_fix_multi) begin
    if (rst_i_fix_multi) begin
      state_q                             <= StIdle;
      step_q                              <= '0;
      acc_q                               <= '0;
      fixed_multiplication_result_Red_o   <= '0;
      fixed_multiplication_result_Green_o <= '0;
      fixed_multiplication_result_Blue_o  <= '0;
      fixed_multiplication_done_o         <= 1'b0;
`ifdef BOOTH_MULT_BUSY_EN
      busy_o_fix_multi                    <= 1'b0;
`endif
    end else begin
      fixed_multiplication_done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en_i_fix_multi) begin
            for (int ch = 0; ch < 3; ch++) begin
              acc_q[ch] <= {{(W + 1){1'b0}}, din[ch], 1'b0};
            end
            step_q  <= '0;
            state_q <= StRun;
`ifdef BOOTH_MULT_BUSY_EN
            busy_o_fix_multi <= 1'b1;
`endif
          end
        end
        StRun: begin
          for (int ch = 0; ch < 3; ch++) begin
            acc_q[ch] <= booth_step(acc_q[ch]);
          end
          step_q <= step_q + CntW'(1);
          if (step_q == LastStep) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          fixed_multiplication_result_Red_o   <= acc_q[0][2*W:1];
          fixed_multiplication_result_Green_o <= acc_q[1][2*W:1];
          fixed_multiplication_result_Blue_o  <= acc_q[2][2*W:1];
          fixed_multiplication_done_o         <= 1'b1;
          state_q                             <= StIdle;
`ifdef BOOTH_MULT_BUSY_EN
          busy_o_fix_multi                    <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult with a product scoreboard; a second instance uses COEFF = -1.0.
module tb_booth_mult;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] dr, dg, db;
  logic [47:0] r, g, b, nr, ng, nb;
  logic        done, n_done;
`ifdef BOOTH_MULT_BUSY_EN
  logic        busy, n_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [47:0] r, g, b, nr;
  } exp_t;
  exp_t sb[$];

  booth_mult dut (
    .clk_i_fix_multi                     (clk),
    .rst_i_fix_multi                     (rst),
    .en_i_fix_multi                      (en),
    .data_i_from_upper_Red               (dr),
    .data_i_from_upper_Green             (dg),
    .data_i_from_upper_Blue              (db),
    .fixed_multiplication_result_Red_o   (r),
    .fixed_multiplication_result_Green_o (g),
    .fixed_multiplication_result_Blue_o  (b),
`ifdef BOOTH_MULT_BUSY_EN
    .busy_o_fix_multi                    (busy),
`endif
    .fixed_multiplication_done_o         (done)
  );

  booth_mult #(.MANTISSA_WIDTH(23), .COEFF(24'h800000)) dut_neg (
    .clk_i_fix_multi                     (clk),
    .rst_i_fix_multi                     (rst),
    .en_i_fix_multi                      (en),
    .data_i_from_upper_Red               (dr),
    .data_i_from_upper_Green             (dg),
    .data_i_from_upper_Blue              (db),
    .fixed_multiplication_result_Red_o   (nr),
    .fixed_multiplication_result_Green_o (ng),
    .fixed_multiplication_result_Blue_o  (nb),
`ifdef BOOTH_MULT_BUSY_EN
    .busy_o_fix_multi                    (n_busy),
`endif
    .fixed_multiplication_done_o         (n_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] model(input logic [23:0] x, input logic [23:0] c);
    logic signed [47:0] p;
    p = $signed(x) * $signed(c);
    return p;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [47:0] er, input logic [47:0] eg,
                      input logic [47:0] eb);
    exp_t e;
    e.tag = tag; e.r = er; e.g = eg; e.b = eb;
    e.nr  = model(dr, 24'h800000);
    sb.push_back(e);
  endtask

  // Waits on negedges for done; latency counts negedges after the call.
  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (done !== 1'b1 && cnt < budget);
  endtask

  task automatic pop_check();
    exp_t e;
    check("sb_nonempty", 48'(sb.size() > 0), 48'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_r"}, r, e.r);
      check({e.tag, "_g"}, g, e.g);
      check({e.tag, "_b"}, b, e.b);
      check({e.tag, "_neg_r"}, nr, e.nr);
      check({e.tag, "_neg_done"}, 48'(n_done), 48'd1);
    end
  endtask

  // Called at a negedge with data already driven and expectation pushed.
  task automatic run_op();
    int cnt;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
`ifdef BOOTH_MULT_BUSY_EN
    check("busy_run", 48'(busy), 48'd1);
`endif
    wait_done(40, cnt);
    check("latency", 48'(cnt), 48'd25);
    pop_check();
    @(negedge clk);
    check("done_single", 48'(done), 48'd0);
`ifdef BOOTH_MULT_BUSY_EN
    check("busy_idle", 48'(busy), 48'd0);
`endif
  endtask

  initial begin
    int cnt;
    rst = 1'b1; en = 1'b1;
    dr = 24'h960000; dg = 24'hA00000; db = 24'hAA0000;
    // Reset held with en high: nothing may start.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_done", 48'(done), 48'd0);
      check("rst_res_r", r, 48'd0);
      check("rst_res_b", b, 48'd0);
    end
    check("rst_res_g", g, 48'd0);
    rst = 1'b0;
    push("neg", 48'hE58000000000, 48'hE80000000000, 48'hEA8000000000);
    run_op();

    @(negedge clk);
    dr = 24'h400000; dg = 24'h400000; db = 24'h400000;
    push("half", 48'h100000000000, 48'h100000000000, 48'h100000000000);
    run_op();

    dr = 24'h800000; dg = 24'h000000; db = 24'h7FFFFF;
    push("extreme", 48'hE00000000000, 48'h000000000000, 48'h1FFFFFC00000);
    run_op();

    dr = 24'h123456; dg = 24'hFEDCBA; db = 24'h000001;
    push("mixed", model(dr, 24'h400000), model(dg, 24'h400000), model(db, 24'h400000));
    run_op();

    // en held high: back-to-back operations, inputs changed mid-RUN.
    dr = 24'h800000; dg = 24'h7FFFFF; db = 24'hC00000;
    push("held1", model(dr, 24'h400000), model(dg, 24'h400000), model(db, 24'h400000));
    check("neg_coeff_ovf", sb[0].nr, 48'h400000000000);
    en = 1'b1;
    wait_done(40, cnt);
    check("held1_latency", 48'(cnt), 48'd26);
    pop_check();
    dr = 24'h0ABCDE; dg = 24'hF00000; db = 24'h3FFFFF;
    push("held2", model(dr, 24'h400000), model(dg, 24'h400000), model(db, 24'h400000));
    for (int i = 0; i < 8; i++) @(negedge clk);
    dr = 24'h555555; dg = 24'h555555; db = 24'h555555;
    wait_done(40, cnt);
    check("period", 48'(cnt + 8), 48'd26);
    en = 1'b0;
    pop_check();
    @(negedge clk);
    check("done_single2", 48'(done), 48'd0);
    wait_done(30, cnt);
    check("no_spurious_done", 48'(cnt), 48'd30);

    // Reset during RUN step 10 aborts the operation.
    dr = 24'h7FFFFF; dg = 24'h7FFFFF; db = 24'h7FFFFF;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_r", r, 48'd0);
    check("abort_g", g, 48'd0);
    check("abort_nr", nr, 48'd0);
    check("abort_done", 48'(done), 48'd0);
`ifdef BOOTH_MULT_BUSY_EN
    check("abort_busy", 48'(busy), 48'd0);
`endif
    wait_done(30, cnt);
    check("abort_no_done", 48'(cnt), 48'd30);

    dr = 24'hA5A5A5; dg = 24'h5A5A5A; db = 24'h800000;
    push("after_abort", model(dr, 24'h400000), model(dg, 24'h400000), model(db, 24'h400000));
    run_op();

    // Results hold until the next done.
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("hold_r", r, model(24'hA5A5A5, 24'h400000));
    check("sb_empty", 48'(sb.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
